mem_access_unit: RTL

- Load/store stage directly downstream of the ALU.
- Takes the ALU-computed address, store data (regD_data) and the decoded load/store strobes.
- Runs a word access on the external data-memory request/ack bus and stalls the core (via its clk_en) until the access retires.
- Returns load data to the register file as a one-cycle write-back pulse.

---
 rtl/mem_access_unit.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store stage: runs one word access on the request/ack memory bus and stalls the core until it retires.
// Optional macro MEM_ACCESS_TIMEOUT_EN aborts an access that waits TIMEOUT_CYCLES without an ack.
module mem_access_unit #(
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              issue_en,
    input  logic              load,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    input  logic [2:0]        dest_reg,
    output logic              stall,
    output logic              wb_en,
    output logic [2:0]        wb_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic              fault,
    output logic [ADDR_W-1:0] fault_addr
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [2:0]        dest_q, dest_d;
    logic              is_load_q, is_load_d;
    logic              abort_q, abort_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
    logic              accept;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
`endif

    assign accept = issue_en & (load | store);

    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        dest_d       = dest_q;
        is_load_d    = is_load_q;
        abort_d      = abort_q;
        wb_data_d    = wb_data_q;
        fault_d      = fault_q;
        fault_addr_d = fault_addr_q;
        stall        = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d        = cnt_q;
        cnt_inc      = cnt_q + CNT_W'(1);
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    stall     = 1'b1;
                    is_load_d = load;
                    dest_d    = dest_reg;
                    if (!addr[0]) begin
                        // Load wins when both strobes are set, so a write only happens for a pure store.
                        mem_req_d   = 1'b1;
                        mem_we_d    = ~load;
                        mem_addr_d  = addr;
                        mem_wdata_d = store_data;
                        abort_d     = 1'b0;
                        state_d     = REQ;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        cnt_d       = '0;
`endif
                    end else begin
                        fault_d = 1'b1;
                        if (!fault_q) fault_addr_d = addr;
                        abort_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ack) begin
                    if (is_load_q) wb_data_d = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = DONE;
                end
`ifdef MEM_ACCESS_TIMEOUT_EN
                else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
                        mem_req_d = 1'b0;
                        abort_d   = 1'b1;
                        fault_d   = 1'b1;
                        if (!fault_q) fault_addr_d = mem_addr_q;
                        state_d   = DONE;
                    end
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            dest_q       <= '0;
            is_load_q    <= 1'b0;
            abort_q      <= 1'b0;
            wb_data_q    <= '0;
            fault_q      <= 1'b0;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            dest_q       <= dest_d;
            is_load_q    <= is_load_d;
            abort_q      <= abort_d;
            wb_data_q    <= wb_data_d;
            fault_q      <= fault_d;
            fault_addr_q <= fault_addr_d;
        end
    end

`ifdef MEM_ACCESS_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

    assign wb_en      = (state_q == DONE) & is_load_q & ~abort_q;
    assign wb_reg     = dest_q;
    assign wb_data    = wb_data_q;
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign fault      = fault_q;
    assign fault_addr = fault_addr_q;

endmodule
